ram_port_arbiter: RTL
=====================

Name: ram_port_arbiter

Overview:
- Two-client round-robin arbiter sitting directly upstream of the team's single-port RAM.
- Serialises read/write transactions from two independent requesters into that RAM's request/ready interface and returns read data plus an ack to the granted client.
- Guarantees exactly one RAM request pulse per client transaction.

Parameters:
- WIDTH, 8, data width in bits (matches RAM WIDTH)
- DEPTH, 256, RAM depth in words
- ADDR_WIDTH, $clog2(DEPTH), address width
- TIMEOUT_CYCLES, 15, max cycles to wait for ram_ready (used only with the optional feature)

Ports:
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- c0_req  in  1  client 0 transaction request; held high until c0_ack
- c0_we  in  1  client 0 write enable (1 = write, 0 = read)
- c0_addr  in  ADDR_WIDTH  client 0 address
- c0_wdata  in  WIDTH  client 0 write data
- c0_rdata  out  WIDTH  client 0 read data, valid when c0_ack=1 and the transaction was a read
- c0_ack  out  1  one-cycle completion pulse to client 0
- c0_err  out  1  one-cycle timeout flag, coincident with c0_ack
- c1_req, c1_we, c1_addr, c1_wdata, c1_rdata, c1_ack, c1_err: same as client 0, for client 1
- ram_request  out  1  one-cycle request pulse to RAM
- ram_write_enable  out  1  to RAM
- ram_addr  out  ADDR_WIDTH  to RAM
- ram_write_data  out  WIDTH  to RAM
- ram_read_data  in  WIDTH  from RAM, valid with ram_ready
- ram_ready  in  1  RAM completion; asserted the cycle after a sampled request

Behaviour:
- All outputs registered.
- Reset values:
  - ram_request, ram_write_enable, ram_addr, ram_write_data = 0
  - cX_ack, cX_err, cX_rdata = 0
  - state = IDLE
  - last_grant = 1, so client 0 wins the first tie
- Reset is honoured in any state. An in-flight transaction is abandoned with no ack; clients re-request after reset.
- FSM states: IDLE, ISSUE, WAIT, RESPOND.
- IDLE:
  - If exactly one cX_req=1, grant it.
  - If both, grant the client != last_grant.
  - On grant, register that client's we/addr/wdata onto the ram_* outputs, set ram_request=1, set last_grant=grant, go to ISSUE.
  - If no request, stay in IDLE.
- ISSUE: ram_request is high for exactly this one cycle; it is cleared on exit. Go to WAIT.
- WAIT:
  - On ram_ready=1, capture ram_read_data into the granted cX_rdata (reads only; writes leave cX_rdata unchanged), set the granted cX_ack=1, go to RESPOND.
- RESPOND: ack is high for this one cycle and cleared on exit. Go to IDLE.
- Latency: req sampled at edge N → ram_request high in cycle N+1 → ram_ready in N+2 → ack high in cycle N+3. Minimum 4 cycles between consecutive grants.
- The client must drop req on the edge after it sees ack. A req still high when IDLE samples is treated as a new transaction.
- The ungranted client's req is held pending; it is never dropped or acked.
- ram_addr and ram_write_data hold their last values outside ISSUE. The RAM ignores them while ram_request=0.
- ram_ready seen outside WAIT is ignored.

Optional Feature:
- Macro: RAM_PORT_ARBITER_TIMEOUT_EN
- Defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYCLES without ram_ready, go to RESPOND with the granted cX_ack=1 and cX_err=1; cX_rdata is unchanged.
  - If ram_ready and the count reaching TIMEOUT_CYCLES occur in the same cycle, the ready wins (err=0).
- Undefined: WAIT waits indefinitely; cX_err is tied 0; no counter is synthesised.

Test Plan:
- Reset, then c0 write addr 0x05 data 0xA5 → ram_request high exactly one cycle with we=1, addr=0x05, wdata=0xA5; c0_ack pulses 3 cycles after the req sample; c1_ack stays 0.
- c1 read addr 0x05 after the previous write → c1_ack pulse with c1_rdata=0xA5, c1_err=0.
- c0_req and c1_req asserted in the same cycle right after reset → c0 granted first, c1 granted on the next IDLE; the RAM sees exactly two request pulses in order c0, c1.
- Both clients requesting back-to-back continuously for 6 transactions → grants alternate c0, c1, c0, c1, …; each ack is one cycle; no double-issue.
- Reset asserted while in WAIT → no ack issued, all outputs return to reset values next cycle; a subsequent c1 req completes normally.
- (TIMEOUT_EN) RAM model withholds ram_ready → ack+err pulse after 15 WAIT cycles; ready arriving at count 15 → ack with err=0.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// Two-client round-robin arbiter feeding the single-port RAM request/ready port.
// Define RAM_PORT_ARBITER_TIMEOUT_EN to bound the wait for ram_ready (ack + err on expiry).
module ram_port_arbiter #(
  parameter int WIDTH          = 8,
  parameter int DEPTH          = 256,
  parameter int ADDR_WIDTH     = $clog2(DEPTH),
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  c0_req,
  input  logic                  c0_we,
  input  logic [ADDR_WIDTH-1:0] c0_addr,
  input  logic [WIDTH-1:0]      c0_wdata,
  output logic [WIDTH-1:0]      c0_rdata,
  output logic                  c0_ack,
  output logic                  c0_err,
  input  logic                  c1_req,
  input  logic                  c1_we,
  input  logic [ADDR_WIDTH-1:0] c1_addr,
  input  logic [WIDTH-1:0]      c1_wdata,
  output logic [WIDTH-1:0]      c1_rdata,
  output logic                  c1_ack,
  output logic                  c1_err,
  output logic                  ram_request,
  output logic                  ram_write_enable,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [WIDTH-1:0]      ram_write_data,
  input  logic [WIDTH-1:0]      ram_read_data,
  input  logic                  ram_ready
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} state_t;

  state_t state;
  logic   last_grant;
  logic   grant;
  logic   grant_next;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  // On a tie the client that did not win last time is chosen.
  always_comb begin
    grant_next = 1'b0;
    if (c0_req && c1_req) grant_next = ~last_grant;
    else if (c1_req)      grant_next = 1'b1;
  end

`ifdef RAM_PORT_ARBITER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] COUNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] wait_count;
`else
  assign c0_err = 1'b0;
  assign c1_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      last_grant       <= 1'b1;
      grant            <= 1'b0;
      ram_request      <= 1'b0;
      ram_write_enable <= 1'b0;
      ram_addr         <= '0;
      ram_write_data   <= '0;
      c0_rdata         <= '0;
      c1_rdata         <= '0;
      c0_ack           <= 1'b0;
      c1_ack           <= 1'b0;
`ifdef RAM_PORT_ARBITER_TIMEOUT_EN
      c0_err           <= 1'b0;
      c1_err           <= 1'b0;
      wait_count       <= '0;
`endif
    end else begin
      c0_ack <= 1'b0;
      c1_ack <= 1'b0;
`ifdef RAM_PORT_ARBITER_TIMEOUT_EN
      c0_err <= 1'b0;
      c1_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (c0_req || c1_req) begin
            grant            <= grant_next;
            last_grant       <= grant_next;
            ram_write_enable <= grant_next ? c1_we    : c0_we;
            ram_addr         <= grant_next ? c1_addr  : c0_addr;
            ram_write_data   <= grant_next ? c1_wdata : c0_wdata;
            ram_request      <= 1'b1;
            state            <= ISSUE;
          end
        end
        ISSUE: begin
          ram_request <= 1'b0;
`ifdef RAM_PORT_ARBITER_TIMEOUT_EN
          wait_count  <= '0;
`endif
          state       <= WAIT;
        end
        WAIT: begin
          // Ready takes priority over a timeout landing on the same cycle.
          if (ram_ready) begin
            if (!ram_write_enable) begin
              if (grant) c1_rdata <= ram_read_data;
              else       c0_rdata <= ram_read_data;
            end
            if (grant) c1_ack <= 1'b1;
            else       c0_ack <= 1'b1;
            state <= RESPOND;
          end
`ifdef RAM_PORT_ARBITER_TIMEOUT_EN
          else if (wait_count == COUNT_LAST) begin
            if (grant) begin
              c1_ack <= 1'b1;
              c1_err <= 1'b1;
            end else begin
              c0_ack <= 1'b1;
              c0_err <= 1'b1;
            end
            state <= RESPOND;
          end else begin
            wait_count <= wait_count + 1'b1;
          end
`endif
        end
        RESPOND: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
